// File: rtl/qracc_pkg.sv
// qracc_pkg: types and constants shared across the QR accelerator control blocks.
//   sram_seq_state_t : phase encoding of the SRAM control sequencer
//   sram_timing_t    : precharge / wordline / sense phase lengths in clocks
//   to_sram_t        : one SRAM word request as carried toward the sequencer
package qracc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRECH,
    WLON,
    SENSE,
    RDOUT
  } sram_seq_state_t;

  typedef struct packed {
    logic [7:0] pch_cycles;
    logic [7:0] wl_cycles;
    logic [7:0] sa_cycles;
  } sram_timing_t;

  localparam sram_timing_t SRAM_TIMING_DEFAULT = '{
    pch_cycles: 8'd1,
    wl_cycles:  8'd2,
    sa_cycles:  8'd1
  };

  localparam int SRAM_ROWS   = 128;
  localparam int SRAM_COLS   = 32;
  localparam int SRAM_ADDR_W = $clog2(SRAM_ROWS);

  typedef struct packed {
    logic                   valid;
    logic                   wr;
    logic [SRAM_ADDR_W-1:0] addr;
    logic [SRAM_COLS-1:0]   wr_data;
    logic [SRAM_COLS-1:0]   wr_mask;
  } to_sram_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/qracc_row_decoder.sv
// qracc_row_decoder: registered one-hot row decode.
//   clk, rst : clock, asynchronous active-high reset
//   en       : drive a row on the next cycle
//   addr     : row address (may exceed num_rows-1)
//   rows     : registered one-hot row selects, all zero when disabled or out of range
module qracc_row_decoder #(
  parameter int num_rows = 128,
  parameter int addr_w   = $clog2(num_rows)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [addr_w-1:0]   addr,
  output logic [num_rows-1:0] rows
);

  localparam logic [addr_w:0] row_limit = (addr_w + 1)'(num_rows);

  logic in_range;

  // Extra top bit so the limit itself is representable when num_rows is a power of two.
  assign in_range = ({1'b0, addr} < row_limit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rows <= '0;
    end else begin
      rows <= '0;
      if (en && in_range) begin
        rows[addr] <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/qracc_sram_seq.sv
// qracc_sram_seq: turns ready/valid SRAM word requests into the analog macro's
// precharge / wordline / write-drive / sense-amp control sequence.
//   clk, rst                       : clock, asynchronous active-high reset
//   rq_valid_i, rq_ready_o         : request handshake
//   rq_wr_i, addr_i                : write/read select, row address
//   wr_data_i, wr_mask_i           : write word and per-column write enable
//   rd_valid_o, rd_data_o          : one-cycle read completion pulse and held read word
//   busy_o                         : sequence in progress
//   wl_o, pch_o, write_o           : wordlines, bitline precharge, write drivers enable
//   wr_data_o, csel_o, saen_o      : write driver data, column select, sense-amp enable
//   sa_out_i                       : sense-amp outputs from the array
module qracc_sram_seq
  import qracc_pkg::*;
#(
  parameter int numRows   = 128,
  parameter int numCols   = 32,
  parameter int pchCycles = int'(SRAM_TIMING_DEFAULT.pch_cycles),
  parameter int wlCycles  = int'(SRAM_TIMING_DEFAULT.wl_cycles),
  parameter int saCycles  = int'(SRAM_TIMING_DEFAULT.sa_cycles)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rq_valid_i,
  output logic                       rq_ready_o,
  input  logic                       rq_wr_i,
  input  logic [$clog2(numRows)-1:0] addr_i,
  input  logic [numCols-1:0]         wr_data_i,
  input  logic [numCols-1:0]         wr_mask_i,
  output logic                       rd_valid_o,
  output logic [numCols-1:0]         rd_data_o,
  output logic                       busy_o,
  output logic [numRows-1:0]         wl_o,
  output logic                       pch_o,
  output logic                       write_o,
  output logic [numCols-1:0]         wr_data_o,
  output logic [numCols-1:0]         csel_o,
  output logic                       saen_o,
  input  logic [numCols-1:0]         sa_out_i
);

  localparam int addr_w     = $clog2(numRows);
  localparam int max_cycles = max3(pchCycles, wlCycles, saCycles);
  localparam int cnt_w      = $clog2(max_cycles) + 1;

  localparam logic [cnt_w-1:0] pch_last = cnt_w'(pchCycles - 1);
  localparam logic [cnt_w-1:0] wl_last  = cnt_w'(wlCycles - 1);
  localparam logic [cnt_w-1:0] sa_last  = cnt_w'(saCycles - 1);
  localparam logic [addr_w:0]  row_limit = (addr_w + 1)'(numRows);

  if (pchCycles < 1 || wlCycles < 1 || saCycles < 1 || numCols < 1) begin : g_param_check
    $fatal(1, "qracc_sram_seq: phase cycle counts and numCols must all be >= 1");
  end

  sram_seq_state_t     state;
  logic [cnt_w-1:0]    cnt;
  logic                req_wr;
  logic [addr_w-1:0]   req_addr;
  logic [numCols-1:0]  req_data;
  logic [numCols-1:0]  req_mask;
  logic                req_in_range;
  logic                accept;
  logic                phase_last;
  logic                wl_next;

  assign accept = rq_valid_i && rq_ready_o;

  always_comb begin
    phase_last = 1'b0;
    case (state)
      PRECH:   phase_last = (cnt == pch_last);
      WLON:    phase_last = (cnt == wl_last);
      SENSE:   phase_last = (cnt == sa_last);
      default: phase_last = 1'b0;
    endcase
  end

  // The decoder is registered, so it is told one cycle ahead whether a wordline
  // is wanted: it rises on the edge that ends precharge and stays up through
  // sensing, falling on the edge that ends the last wordline/sense cycle.
  always_comb begin
    wl_next = 1'b0;
    case (state)
      PRECH:   wl_next = phase_last;
      WLON:    wl_next = !(phase_last && req_wr);
      SENSE:   wl_next = !phase_last;
      default: wl_next = 1'b0;
    endcase
  end

  qracc_row_decoder #(
    .num_rows (numRows),
    .addr_w   (addr_w)
  ) u_row_decoder (
    .clk  (clk),
    .rst  (rst),
    .en   (wl_next),
    .addr (req_addr),
    .rows (wl_o)
  );

  // Writes also pass through RDOUT (without a read pulse) so that every
  // sequence ends with a full all-controls-low cycle before ready returns.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      req_wr       <= 1'b0;
      req_addr     <= '0;
      req_data     <= '0;
      req_mask     <= '0;
      req_in_range <= 1'b0;
      rq_ready_o   <= 1'b0;
      busy_o       <= 1'b0;
      rd_valid_o   <= 1'b0;
      rd_data_o    <= '0;
      pch_o        <= 1'b0;
      write_o      <= 1'b0;
      wr_data_o    <= '0;
      csel_o       <= '0;
      saen_o       <= 1'b0;
    end else begin
      rd_valid_o <= 1'b0;
      cnt        <= cnt + cnt_w'(1);
      case (state)
        IDLE: begin
          cnt <= '0;
          if (accept) begin
            state        <= PRECH;
            req_wr       <= rq_wr_i;
            req_addr     <= addr_i;
            req_data     <= wr_data_i;
            req_mask     <= wr_mask_i;
            req_in_range <= ({1'b0, addr_i} < row_limit);
            rq_ready_o   <= 1'b0;
            busy_o       <= 1'b1;
            pch_o        <= 1'b1;
          end else begin
            rq_ready_o <= 1'b1;
          end
        end
        PRECH: begin
          if (phase_last) begin
            state     <= WLON;
            cnt       <= '0;
            pch_o     <= 1'b0;
            write_o   <= req_wr;
            wr_data_o <= req_wr ? req_data : '0;
            csel_o    <= req_wr ? req_mask : '1;
          end
        end
        WLON: begin
          if (phase_last) begin
            cnt       <= '0;
            write_o   <= 1'b0;
            wr_data_o <= '0;
            if (req_wr) begin
              state  <= RDOUT;
              csel_o <= '0;
            end else begin
              state  <= SENSE;
              saen_o <= 1'b1;
            end
          end
        end
        SENSE: begin
          if (phase_last) begin
            state     <= RDOUT;
            cnt       <= '0;
            saen_o    <= 1'b0;
            csel_o    <= '0;
            rd_data_o <= req_in_range ? sa_out_i : '0;
          end
        end
        RDOUT: begin
          state      <= IDLE;
          cnt        <= '0;
          busy_o     <= 1'b0;
          rq_ready_o <= 1'b1;
          rd_valid_o <= !req_wr;
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
